instr_fetch: RTL and testbench



---
 rtl/instr_fetch_if.sv | 24 ++
 rtl/instr_fetch.sv | 101 ++++++++++
 tb/tb_instr_fetch.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - instruction-memory, pipeline-control and IF/ID signals of the fetch stage
interface instr_fetch_if;
  logic [31:0] im_addr;
  logic [31:0] im_instr;
  logic        stall;
  logic        flush;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] id_instr;
  logic [31:0] id_pc4;
  logic        id_valid;
  logic        halted;
  logic [31:0] fetch_count;

  modport master (
    output im_addr, id_instr, id_pc4, id_valid, halted, fetch_count,
    input  im_instr, stall, flush, redirect, redirect_pc
  );

  modport slave (
    input  im_addr, id_instr, id_pc4, id_valid, halted, fetch_count,
    output im_instr, stall, flush, redirect, redirect_pc
  );
endinterface

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - MIPS fetch stage: PC, IF/ID register, stall/flush/redirect, halt after last word
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter logic [31:0] LAST_PC  = 32'd56
) (
  input  logic            clk,
  input  logic            rst_n,
  instr_fetch_if.master   fif
);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic [31:0] id_pc4_q, id_pc4_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] fetch_count_q, fetch_count_d;

  logic [31:0] pc_plus4;
  logic [31:0] redirect_target;

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    id_instr_d      = id_instr_q;
    id_pc4_d        = id_pc4_q;
    id_valid_d      = id_valid_q;
    fetch_count_d   = fetch_count_q;
    pc_plus4        = pc_q + 32'd4;
    redirect_target = fif.redirect_pc & ~32'h3;

    case (state_q)
      IDLE: state_d = RUN;

      RUN: begin
        if (fif.redirect) begin
          pc_d       = redirect_target;
          id_valid_d = 1'b0;
          id_instr_d = '0;
          id_pc4_d   = '0;
        end else if (fif.flush) begin
          id_valid_d = 1'b0;
          id_instr_d = '0;
          id_pc4_d   = '0;
          if (!fif.stall) pc_d = pc_plus4;
        end else if (!fif.stall) begin
          id_instr_d = fif.im_instr;
          id_pc4_d   = pc_plus4;
          id_valid_d = 1'b1;
          pc_d       = pc_plus4;
          if (fetch_count_q != 32'hFFFF_FFFF) fetch_count_d = fetch_count_q + 32'd1;
          if (pc_q == LAST_PC) state_d = HALT;
        end
      end

      HALT: begin
        // PC stays at LAST_PC+4; only a redirect restarts fetching.
        if (fif.redirect) begin
          pc_d       = redirect_target;
          id_valid_d = 1'b0;
          id_instr_d = '0;
          id_pc4_d   = '0;
          state_d    = RUN;
        end else if (fif.flush || !fif.stall) begin
          id_valid_d = 1'b0;
          id_instr_d = '0;
          id_pc4_d   = '0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      id_instr_q    <= '0;
      id_pc4_q      <= '0;
      id_valid_q    <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      id_instr_q    <= id_instr_d;
      id_pc4_q      <= id_pc4_d;
      id_valid_q    <= id_valid_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign fif.im_addr     = pc_q;
  assign fif.id_instr    = id_instr_q;
  assign fif.id_pc4      = id_pc4_q;
  assign fif.id_valid    = id_valid_q;
  assign fif.halted      = (state_q == HALT);
  assign fif.fetch_count = fetch_count_q;

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed self-checking bench for instr_fetch
module tb_instr_fetch;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  instr_fetch_if fif();

  instr_fetch #(.RESET_PC(32'd0), .LAST_PC(32'd56)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .fif   (fif)
  );

  // Instruction memory model: word at index i reads as A000_0000 | i.
  assign fif.im_instr = 32'hA000_0000 | (fif.im_addr >> 2);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] idx);
    return 32'hA000_0000 | idx;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    fif.stall = 1'b0; fif.flush = 1'b0; fif.redirect = 1'b0; fif.redirect_pc = '0;
    #1;
    chk("reset_im_addr", fif.im_addr, 32'd0);
    chk("reset_id_instr", fif.id_instr, 32'd0);
    chk("reset_id_pc4", fif.id_pc4, 32'd0);
    chk("reset_id_valid", {31'd0, fif.id_valid}, 32'd0);
    chk("reset_halted", {31'd0, fif.halted}, 32'd0);
    chk("reset_fetch_count", fif.fetch_count, 32'd0);
    step();
    step();
  endtask

  task automatic test_sequential();
    rst_n = 1'b1;
    step();
    chk("idle_valid", {31'd0, fif.id_valid}, 32'd0);
    chk("idle_pc", fif.im_addr, 32'd0);
    for (int k = 1; k <= 15; k++) begin
      step();
      chk("seq_pc4", fif.id_pc4, 32'(4 * k));
      chk("seq_instr", fif.id_instr, word(32'(k - 1)));
      chk("seq_valid", {31'd0, fif.id_valid}, 32'd1);
    end
    chk("seq_halted", {31'd0, fif.halted}, 32'd1);
    chk("seq_fetch_count", fif.fetch_count, 32'd15);
    chk("seq_halt_pc", fif.im_addr, 32'd60);
    step();
    chk("halt_valid_clear", {31'd0, fif.id_valid}, 32'd0);
    chk("halt_pc_frozen", fif.im_addr, 32'd60);
    chk("halt_still_halted", {31'd0, fif.halted}, 32'd1);
    chk("halt_count_hold", fif.fetch_count, 32'd15);
  endtask

  task automatic test_halt_redirect();
    fif.redirect = 1'b1; fif.redirect_pc = 32'd0;
    step();
    fif.redirect = 1'b0;
    chk("hred_halted", {31'd0, fif.halted}, 32'd0);
    chk("hred_pc", fif.im_addr, 32'd0);
    chk("hred_valid", {31'd0, fif.id_valid}, 32'd0);
    step();
    chk("hred_instr", fif.id_instr, word(32'd0));
    chk("hred_pc4", fif.id_pc4, 32'd4);
    chk("hred_count", fif.fetch_count, 32'd16);
    step();
    chk("pre_stall_pc", fif.im_addr, 32'd8);
  endtask

  task automatic test_stall();
    fif.stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall_pc", fif.im_addr, 32'd8);
      chk("stall_instr", fif.id_instr, word(32'd1));
      chk("stall_count", fif.fetch_count, 32'd17);
      chk("stall_valid", {31'd0, fif.id_valid}, 32'd1);
    end
    fif.stall = 1'b0;
    step();
    chk("unstall_instr", fif.id_instr, word(32'd2));
    chk("unstall_pc4", fif.id_pc4, 32'd12);
    chk("unstall_count", fif.fetch_count, 32'd18);
    chk("unstall_pc", fif.im_addr, 32'd12);
  endtask

  task automatic test_redirect();
    fif.redirect = 1'b1; fif.redirect_pc = 32'h23;
    step();
    fif.redirect = 1'b0;
    chk("red_valid", {31'd0, fif.id_valid}, 32'd0);
    chk("red_pc", fif.im_addr, 32'h20);
    step();
    chk("red_pc4", fif.id_pc4, 32'h24);
    chk("red_instr", fif.id_instr, word(32'd8));
    chk("red_valid2", {31'd0, fif.id_valid}, 32'd1);
    chk("red_count", fif.fetch_count, 32'd19);
  endtask

  task automatic test_flush_stall();
    fif.redirect = 1'b1; fif.redirect_pc = 32'd16;
    step();
    fif.redirect = 1'b0;
    fif.flush = 1'b1; fif.stall = 1'b1;
    step();
    chk("fs_valid", {31'd0, fif.id_valid}, 32'd0);
    chk("fs_pc", fif.im_addr, 32'd16);
    chk("fs_instr_zero", fif.id_instr, 32'd0);
    fif.redirect = 1'b1; fif.redirect_pc = 32'd40;
    step();
    chk("fsr_pc", fif.im_addr, 32'd40);
    chk("fsr_valid", {31'd0, fif.id_valid}, 32'd0);
    fif.redirect = 1'b0; fif.stall = 1'b0;
    step();
    chk("flush_pc_adv", fif.im_addr, 32'd44);
    chk("flush_valid", {31'd0, fif.id_valid}, 32'd0);
    chk("flush_count", fif.fetch_count, 32'd19);
    fif.flush = 1'b0;
  endtask

  task automatic test_redirect_at_last();
    fif.redirect = 1'b1; fif.redirect_pc = 32'd56;
    step();
    fif.redirect_pc = 32'd8;
    step();
    fif.redirect = 1'b0;
    chk("rlast_halted", {31'd0, fif.halted}, 32'd0);
    chk("rlast_pc", fif.im_addr, 32'd8);
    chk("rlast_valid", {31'd0, fif.id_valid}, 32'd0);
    chk("rlast_count", fif.fetch_count, 32'd19);
  endtask

  task automatic test_wrap();
    fif.redirect = 1'b1; fif.redirect_pc = 32'hFFFF_FFFE;
    step();
    fif.redirect = 1'b0;
    chk("wrap_target", fif.im_addr, 32'hFFFF_FFFC);
    step();
    chk("wrap_pc4", fif.id_pc4, 32'd0);
    chk("wrap_pc", fif.im_addr, 32'd0);
    chk("wrap_instr", fif.id_instr, word(32'h3FFF_FFFF));
    chk("wrap_count", fif.fetch_count, 32'd20);
  endtask

  task automatic test_async_reset();
    fif.redirect = 1'b1; fif.redirect_pc = 32'd20;
    step();
    fif.redirect = 1'b0;
    step();
    chk("ar_pre_pc", fif.im_addr, 32'd24);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_pc", fif.im_addr, 32'd0);
    chk("ar_count", fif.fetch_count, 32'd0);
    chk("ar_valid", {31'd0, fif.id_valid}, 32'd0);
    chk("ar_instr", fif.id_instr, 32'd0);
    chk("ar_pc4", fif.id_pc4, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("ar_idle_valid", {31'd0, fif.id_valid}, 32'd0);
    chk("ar_idle_pc", fif.im_addr, 32'd0);
    step();
    chk("ar_first_pc4", fif.id_pc4, 32'd4);
    chk("ar_first_instr", fif.id_instr, word(32'd0));
    chk("ar_first_count", fif.fetch_count, 32'd1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_sequential();
    test_halt_redirect();
    test_stall();
    test_redirect();
    test_flush_stall();
    test_redirect_at_last();
    test_wrap();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
